// File: rtl/rr_arbiter_x_in.sv
// rr_arbiter_x_in: round-robin arbiter with packet lock for a NoC router port.
// A winner is chosen by rotating priority, holds the grant until its tail flit
// is accepted (or its request drops), then the pointer moves past the winner.
// Optional feature macro: RR_X_IN_B2B_EN (back-to-back grants, no idle bubble).
module rr_arbiter_x_in #(
   parameter int IO_SIZE = 5,
   parameter int IO_w    = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IO_SIZE-1:0] req,
   input  logic               last,
   input  logic               ack,
   output logic [IO_SIZE-1:0] grant,
   output logic [IO_w-1:0]    grant_id,
   output logic               grant_vld
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [IO_SIZE-1:0] grant_q, grant_d;
   logic [IO_w-1:0]    grant_id_q, grant_id_d;
   logic [IO_w-1:0]    ptr_q, ptr_d;
   logic [IO_w-1:0]    arb_base;
   logic [IO_w-1:0]    win_id;
   logic               win_found;
   logic               release_pkt;

   // While busy the search starts after the current holder, which equals the
   // pointer value it will leave behind on release.
   assign arb_base = (state_q == BUSY) ? grant_id_q : ptr_q;

   // A packet closes on an accepted tail flit, or aborts when its request drops.
   assign release_pkt = (state_q == BUSY) && ((ack && last) || !req[grant_id_q]);

   // Scan requesters in rotating order base+1 .. base and pick the first set one.
   always_comb begin
      int              idx;
      logic [IO_w-1:0] idx_v;
      win_id    = '0;
      win_found = 1'b0;
      idx       = 0;
      idx_v     = '0;
      for (int i = 1; i <= IO_SIZE; i++) begin
         idx = int'(arb_base) + i;
         if (idx >= IO_SIZE) idx = idx - IO_SIZE;
         idx_v = IO_w'(idx);
         if (!win_found && req[idx_v]) begin
            win_found = 1'b1;
            win_id    = idx_v;
         end
      end
   end

   // Next-state logic: grant on request when idle, hold while busy, release on tail or abort.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      ptr_d      = ptr_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d    = IO_SIZE'(1) << win_id;
               grant_id_d = win_id;
               state_d    = BUSY;
            end else begin
               grant_d    = '0;
               grant_id_d = '0;
            end
         end
         BUSY: begin
            if (release_pkt) begin
               ptr_d = grant_id_q;
`ifdef RR_X_IN_B2B_EN
               if (win_found) begin
                  grant_d    = IO_SIZE'(1) << win_id;
                  grant_id_d = win_id;
                  state_d    = BUSY;
               end else begin
                  grant_d    = '0;
                  grant_id_d = '0;
                  state_d    = IDLE;
               end
`else
               grant_d    = '0;
               grant_id_d = '0;
               state_d    = IDLE;
`endif
            end
         end
         default: begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = '0;
         end
      endcase
   end

   // State, grant and pointer registers; pointer resets so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         ptr_q      <= IO_w'(IO_SIZE - 1);
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
      end
   end

   assign grant     = grant_q;
   assign grant_id  = grant_id_q;
   assign grant_vld = |grant_q;

endmodule
